logic_stream_unit: RTL

- Parametrised successor to the team's single-gate AND/NOT exercise blocks: a WIDTH-bit registered logic unit that supports eight bitwise operations.
- Two modes:
  - Single-shot: one result per accepted operand pair.
  - Reduce: folds a multi-beat operand stream into one result.
- Sits between a valid/ready producer and consumer in the lab datapath.
- Doubles as the reference DUT for the handshake testbenches.

---
 rtl/logic_stream_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/logic_stream_unit.sv
// logic_stream_unit: WIDTH-bit registered 8-op logic unit with single-shot and reduce (stream fold) modes over valid/ready; LOGIC_STREAM_PARITY_EN adds out_parity
module logic_stream_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef LOGIC_STREAM_PARITY_EN
  ,
  output logic             out_parity
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_idle;
  logic             w_accept;
  logic             w_single;
  logic             w_done;
  logic             w_inv;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (op == 3'd0 || op == 3'd3) ? (x & y) :
           (op == 3'd1 || op == 3'd4) ? (x | y) :
           (op == 3'd2 || op == 3'd5) ? (x ^ y) :
           (op == 3'd6) ? ~x : x;
  endfunction
  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_count = r_count;
  assign w_idle    = (r_state == IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_single  = w_idle & ~in_mode;
  assign w_done    = w_single | in_last;
  assign w_op      = w_idle ? in_op : r_op;
  assign w_inv     = (w_op >= 3'd3) && (w_op <= 3'd5);
  assign w_acc_nxt = w_idle ? ((in_op == 3'd6) ? ~in_a : in_a) : f_op(r_op, in_a, r_acc);
  assign w_res     = w_single ? f_op(in_op, in_a, in_b) : w_acc_nxt;
  assign w_out_nxt = w_inv ? ~w_res : w_res;
  assign w_cnt_nxt = w_idle ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_count <= '0;
`ifdef LOGIC_STREAM_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_idle) r_op <= in_op;
      if (w_done) begin
        r_data  <= w_out_nxt;
        r_count <= w_cnt_nxt;
        r_state <= HOLD;
`ifdef LOGIC_STREAM_PARITY_EN
        out_parity <= ^w_out_nxt;
`endif
      end else begin
        r_state <= ACCUM;
      end
    end else if (out_valid && out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule
